// File: rtl/logu_pkg.sv
// Shared types and helpers for the bit-serial logic-unit sequencer.
// Opcode encodings, FSM states and opcode-to-unit select mapping.
package logu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_SHL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op <= OP_SHL;
  endfunction

  // SHL is an OR against a zeroed B on a pre-shifted A
  function automatic logic [2:0] lu_sel(
    input logic [2:0] op
  );
    return (op == OP_SHL) ? OP_OR : op;
  endfunction

endpackage

// File: rtl/logu_serial_ctrl.sv
// Bit-serial sequencer driving an external 1-bit logic unit, LSB first.
// Accepts one op in IDLE, shifts WIDTH bits in RUN, holds result in DONE.
module logu_serial_ctrl
  import logu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy,
  output logic             lu_a,
  output logic             lu_b,
  output logic [2:0]       lu_opsel,
  input  logic             lu_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       sel_q;
  logic             err_q;

  logic is_idle, is_run, is_done;
  logic accept, last;

  assign is_idle = (state_q == IDLE);
  assign is_run  = (state_q == RUN);
  assign is_done = (state_q == DONE);
  assign accept  = is_idle && in_valid;
  assign last    = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      is_idle: if (accept)
                 state_d = op_legal(op) ? RUN : DONE;
      is_run:  if (last) state_d = DONE;
      is_done: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
      sel_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        result_q <= '0;
        if (op_legal(op)) begin
          err_q <= 1'b0;
          sel_q <= lu_sel(op);
          if (op == OP_SHL) begin
            a_sr_q <= {a[WIDTH-2:0], 1'b0};
            b_sr_q <= '0;
          end else begin
            a_sr_q <= a;
            b_sr_q <= b;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
      if (is_run) begin
        result_q <= {lu_out, result_q[WIDTH-1:1]};
        a_sr_q   <= a_sr_q >> 1;
        b_sr_q   <= b_sr_q >> 1;
        if (!last) cnt_q <= cnt_q + 1'b1;
      end
      if (is_done && out_ready) err_q <= 1'b0;
    end
  end

  // in_ready is gated so it stays low while reset is held
  assign in_ready  = is_idle && rst_n;
  assign out_valid = is_done;
  assign busy      = is_run || is_done;
  assign result    = result_q;
  assign err       = err_q;
  assign lu_a      = is_run && a_sr_q[0];
  assign lu_b      = is_run && b_sr_q[0];
  assign lu_opsel  = is_run ? sel_q : 3'b000;

endmodule

// File: tb/tb_logu_serial_ctrl.sv
// Directed plus random bench for logu_serial_ctrl with a behavioural
// 1-bit unit and a whole-word reference model.
module tb_logu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         err;
  logic         busy;
  logic         lu_a, lu_b, lu_out;
  logic [2:0]   lu_opsel;

  int total = 0;
  int passed = 0;

  logic [W-1:0] cur_a, cur_b;
  logic [2:0]   cur_op;

  logu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .busy(busy),
    .lu_a(lu_a), .lu_b(lu_b), .lu_opsel(lu_opsel),
    .lu_out(lu_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    lu_out = 1'b0;
    case (lu_opsel)
      3'b000: lu_out = lu_a & lu_b;
      3'b001: lu_out = lu_a | lu_b;
      3'b010: lu_out = lu_a ^ lu_b;
      3'b011: lu_out = ~lu_a;
      default: lu_out = 1'bx;
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [W-1:0] ma,
                                input logic [W-1:0] mb,
                                input logic [2:0] mop,
                                output logic [W-1:0] r,
                                output logic e);
    e = 1'b0;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ma ^ mb;
      3'd3: r = ~ma;
      3'd4: r = ma << 1;
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  task automatic start(input logic [W-1:0] sa, input logic [W-1:0] sb,
                       input logic [2:0] sop);
    int n;
    @(negedge clk);
    a = sa; b = sb; op = sop; in_valid = 1'b1;
    cur_a = sa; cur_b = sb; cur_op = sop;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
  endtask

  task automatic track();
    logic [W-1:0] ea, eb;
    logic [2:0]   es;
    logic         legal;
    int           i;
    legal = (cur_op <= 3'd4);
    ea = (cur_op == 3'd4) ? (cur_a << 1) : cur_a;
    eb = (cur_op == 3'd4) ? '0 : cur_b;
    es = (cur_op == 3'd4) ? 3'd1 : cur_op;
    i = 0;
    @(negedge clk);
    while (!out_valid && i < W + 4) begin
      check("lu_a", lu_a, legal ? ea[0] : 1'b0);
      check("lu_b", lu_b, legal ? eb[0] : 1'b0);
      check("lu_opsel", lu_opsel, legal ? es : 3'd0);
      check("busy_run", busy, 1);
      ea = ea >> 1;
      eb = eb >> 1;
      i++;
      @(negedge clk);
    end
    check("latency", i, legal ? W : 0);
    check("lu_idle", {lu_a, lu_b, lu_opsel}, 0);
  endtask

  task automatic drain(input int hold);
    logic [W-1:0] er;
    logic         ee;
    model(cur_a, cur_b, cur_op, er, ee);
    for (int k = 0; k < hold; k++) begin
      check("hold_result", result, er);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    check("result", result, er);
    check("err", err, ee);
    check("out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_err", err, 0);
    check("post_busy", busy, 0);
  endtask

  initial begin
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_lu", {lu_a, lu_b, lu_opsel}, 0);
    #20 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    start(8'hF0, 8'h3C, 3'b000); track(); drain(0);
    start(8'hAA, 8'hFF, 3'b010); track(); drain(0);
    start(8'hA5, 8'hFF, 3'b011); track(); drain(0);
    start(8'h81, 8'hFF, 3'b100); track(); drain(0);
    start(8'h5A, 8'h33, 3'b110); track(); drain(0);

    // backpressure, with the next op waiting on in_valid
    start(8'h3C, 8'h0F, 3'b001); track();
    a = 8'h96; b = 8'h69; op = 3'b010; in_valid = 1'b1;
    drain(5);
    start(8'h96, 8'h69, 3'b010); track(); drain(1);

    // async reset mid-RUN, then a clean OR
    start(W'($urandom), W'($urandom), 3'b001);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    check("arst_err", err, 0);
    check("arst_lu", {lu_a, lu_b, lu_opsel}, 0);
    check("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst_rel_ready", in_ready, 1);
    start(8'h0F, 8'hF0, 3'b001); track(); drain(0);

    for (int t = 0; t < 30; t++) begin
      start(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      track();
      drain($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
